// File: rtl/spi_bus_arbiter_if.sv
// Pin bundle around the SPI bus arbiter: RPi header side, local master side and STM32 side.
// The arbiter takes the slave modport; whatever drives the header and local pins takes the master modport.
interface spi_bus_arbiter_if;
    logic       RPI_CS_N_IN;
    logic       SPI_CLK_IN;
    logic       SPI_MOSI_IN;
    logic       SPI_MISO_OUT;
    logic       LOC_REQ;
    logic       LOC_GNT;
    logic       LOC_CS_N;
    logic       LOC_SCK;
    logic       LOC_MOSI;
    logic       LOC_MISO;
    logic       SPI_CS_N_OUT;
    logic       SPI_CLK_OUT;
    logic       SPI_MOSI_OUT;
    logic       SPI_MISO_IN;
    logic [1:0] OWNER;
    logic       RPI_BUSY;
    logic       RPI_COLLIDE;
    logic       TIMEOUT_ERR;

    modport slave (
        input  RPI_CS_N_IN, SPI_CLK_IN, SPI_MOSI_IN, LOC_REQ, LOC_CS_N, LOC_SCK, LOC_MOSI, SPI_MISO_IN,
        output SPI_MISO_OUT, LOC_GNT, LOC_MISO, SPI_CS_N_OUT, SPI_CLK_OUT, SPI_MOSI_OUT,
               OWNER, RPI_BUSY, RPI_COLLIDE, TIMEOUT_ERR
    );

    modport master (
        output RPI_CS_N_IN, SPI_CLK_IN, SPI_MOSI_IN, LOC_REQ, LOC_CS_N, LOC_SCK, LOC_MOSI, SPI_MISO_IN,
        input  SPI_MISO_OUT, LOC_GNT, LOC_MISO, SPI_CS_N_OUT, SPI_CLK_OUT, SPI_MOSI_OUT,
               OWNER, RPI_BUSY, RPI_COLLIDE, TIMEOUT_ERR
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares the STM32 SPI bus between the RPi (priority, never stalled) and a local master,
// with a forced idle guard between owners and rejection of RPi frames that start while busy.
module spi_bus_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             CLK,
    input  logic             RST,
    spi_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RPI   = 2'b01,
        ST_LOC   = 2'b10,
        ST_GUARD = 2'b11
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_cs_prev;
    logic                   r_armed;
    logic                   r_collide;
    logic                   r_timeout_err;
    logic [TW-1:0]          r_tcnt;
    logic [GW-1:0]          r_gcnt;
    logic                   w_cs_s;
    logic                   w_cs_fall;
    logic                   w_reject;
    logic                   w_timeout;

    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_cs_fall = r_cs_prev & ~w_cs_s;
    assign w_reject  = w_cs_fall & ((r_state == ST_LOC) || (r_state == ST_GUARD));

    // NOTE: flops update with non-blocking (<=) so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the CS_N synchronizer resets low, not idle-high, so a frame still running at reset release never looks freshly started.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cs_sync     <= '0;
            r_cs_prev     <= 1'b0;
            r_armed       <= 1'b0;
            r_tcnt        <= '0;
            r_gcnt        <= '0;
            r_collide     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cs_sync[0] <= bus.RPI_CS_N_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_cs_sync[i] <= r_cs_sync[i-1];
            end
            r_cs_prev <= w_cs_s;
            if (w_cs_s) begin
                r_armed <= 1'b1;
            end else if (w_reject) begin
                r_armed <= 1'b0;
            end
            // Both counters restart whenever their state is left, so entry always sees zero.
            r_tcnt        <= (r_state == ST_LOC)   ? r_tcnt + 1'b1 : '0;
            r_gcnt        <= (r_state == ST_GUARD) ? r_gcnt + 1'b1 : '0;
            r_collide     <= w_reject;
            r_timeout_err <= w_timeout;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_s && r_armed) begin
                    w_state_next = ST_RPI;
                end else if (bus.LOC_REQ) begin
                    w_state_next = ST_LOC;
                end
            end
            ST_RPI: begin
                if (w_cs_s) begin
                    w_state_next = ST_GUARD;
                end
            end
            ST_LOC: begin
                if (!bus.LOC_REQ) begin
                    w_state_next = ST_GUARD;
                end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next = ST_GUARD;
                    w_timeout    = 1'b1;
                end
            end
            ST_GUARD: begin
                if (r_gcnt == GW'(GUARD_CYCLES - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bus mux follows the registered owner; IDLE and GUARD park the bus with CS_N high.
    always_comb begin
        bus.SPI_CS_N_OUT = 1'b1;
        bus.SPI_CLK_OUT  = 1'b0;
        bus.SPI_MOSI_OUT = 1'b0;
        bus.SPI_MISO_OUT = 1'b0;
        bus.LOC_MISO     = 1'b0;
        case (r_state)
            ST_RPI: begin
                bus.SPI_CS_N_OUT = bus.RPI_CS_N_IN;
                bus.SPI_CLK_OUT  = bus.SPI_CLK_IN;
                bus.SPI_MOSI_OUT = bus.SPI_MOSI_IN;
                bus.SPI_MISO_OUT = bus.SPI_MISO_IN;
            end
            ST_LOC: begin
                bus.SPI_CS_N_OUT = bus.LOC_CS_N;
                bus.SPI_CLK_OUT  = bus.LOC_SCK;
                bus.SPI_MOSI_OUT = bus.LOC_MOSI;
                bus.LOC_MISO     = bus.SPI_MISO_IN;
            end
            default: ;
        endcase
    end

    assign bus.OWNER       = r_state;
    assign bus.LOC_GNT     = (r_state == ST_LOC);
    assign bus.RPI_BUSY    = (r_state == ST_LOC) || (r_state == ST_GUARD);
    assign bus.RPI_COLLIDE = r_collide;
    assign bus.TIMEOUT_ERR = r_timeout_err;
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single downstream SPI bus to the STM32 between two masters: the Raspberry Pi SPI port and a local CPLD-internal master (register poller, EEPROM/ID fetcher). The RPi has priority but cannot be stalled, so a frame it starts while the bus is busy is rejected and flagged rather than corrupted. A guard interval separates every ownership change so the STM32 sees a clean CS_N deassertion between frames. The block sits between the RPi header pins and the STM32 SPI pins, in place of a plain wire-through.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for RPI_CS_N_IN.
- GUARD_CYCLES, 4: CLK cycles of forced bus idle after each ownership ends (≥1).
- TIMEOUT_CYCLES, 65535: maximum CLK cycles the local master may hold the bus.

Ports (name, direction, width, meaning):
- CLK  in  1  system clock; the only clock in the block.
- RST  in  1  asynchronous, active-high reset.
- RPI_CS_N_IN  in  1  RPi chip select (async to CLK).
- SPI_CLK_IN, SPI_MOSI_IN  in  1  RPi SCK/MOSI.
- SPI_MISO_OUT  out  1  MISO to RPi.
- LOC_REQ  in  1  local master bus request (CLK domain).
- LOC_GNT  out  1  local master grant.
- LOC_CS_N, LOC_SCK, LOC_MOSI  in  1  local master SPI drive.
- LOC_MISO  out  1  MISO to local master.
- SPI_CS_N_OUT, SPI_CLK_OUT, SPI_MOSI_OUT  out  1  to STM32.
- SPI_MISO_IN  in  1  from STM32.
- OWNER  out  2  current state encoding.
- RPI_BUSY  out  1  bus unavailable to RPi (to an RPi GPIO).
- RPI_COLLIDE  out  1  one-cycle pulse: RPi frame rejected.
- TIMEOUT_ERR  out  1  one-cycle pulse: local master timed out.

## Operation
- States (OWNER code): IDLE 00, RPI 01, LOC 10, GUARD 11.
- cs_s = RPI_CS_N_IN after SYNC_STAGES flops; armed bit set whenever cs_s=1, cleared on reject.
- IDLE: cs_s=0 and armed → RPI; else LOC_REQ=1 → LOC. Both true in the same cycle → RPI wins.
- RPI: stays until cs_s=1 → GUARD. LOC_REQ is held pending.
- LOC: LOC_GNT=1; LOC_REQ=0 → GUARD; tcnt reaches TIMEOUT_CYCLES-1 → GUARD, TIMEOUT_ERR pulse, LOC_GNT drops.
- GUARD: gcnt counts; after exactly GUARD_CYCLES cycles → IDLE.
- Reject: a cs_s falling edge while in LOC or GUARD → RPI_COLLIDE pulse, armed=0. That frame is never granted, even if still active when IDLE is reached.
- Bus mux (combinational from registered state):
  - RPI: downstream = RPi pins; SPI_MISO_OUT = SPI_MISO_IN.
  - LOC: downstream = LOC_* pins; LOC_MISO = SPI_MISO_IN.
  - IDLE/GUARD: CS_N=1, SCK=0, MOSI=0.
  - A non-owner's MISO is 0.
- RPI_BUSY = 1 in LOC and GUARD.
- tcnt width = clog2(TIMEOUT_CYCLES+1); tcnt clears on LOC entry. gcnt clears on GUARD entry.
- Reset values:
  - State IDLE, armed=0.
  - LOC_GNT=0, RPI_BUSY=0, OWNER=00, RPI_COLLIDE=0, TIMEOUT_ERR=0.
  - SPI_CS_N_OUT=1, SPI_CLK_OUT=0, SPI_MOSI_OUT=0, both MISO outputs 0.
- Reset mid-frame: bus released immediately. An RPi frame in progress is not granted, because armed=0 until cs_s is seen high.

## Timing
- RPi grant: falling RPI_CS_N_IN → cs_s low after SYNC_STAGES edges → OWNER=01 at the next edge. RPi driver must hold ≥ SYNC_STAGES+2 CLK periods from CS_N low to first SCK edge.
- RPi release: CS_N high → GUARD after SYNC_STAGES+1 edges.
- Local: LOC_REQ high at edge t → LOC_GNT=1 after edge t+1 (1-cycle latency). Local master drives LOC_CS_N low only while LOC_GNT=1. LOC_REQ low → GUARD next edge.
- The GUARD→IDLE→grant path adds 1 cycle after the guard ends.
- Timeout: LOC_GNT high for exactly TIMEOUT_CYCLES cycles max.
- Pulses are registered and one CLK wide.

## Test plan
- Reset then LOC_REQ=1 held 10 cycles then 0 → LOC_GNT high cycles 2–11, OWNER 10, then GUARD 4 cycles, then 00; downstream mirrors LOC_SCK/MOSI only while granted.
- RPi CS_N low, 16 SCK toggles, CS_N high (LOC_REQ idle) → OWNER=01 after 3 CLK, SPI_CLK_OUT follows SPI_CLK_IN, SPI_MISO_OUT = SPI_MISO_IN, then GUARD 4 cycles.
- LOC_REQ and synchronized RPi CS_N low in the same IDLE cycle → OWNER=01, LOC_GNT stays 0 until RPi frame + guard complete, then LOC granted.
- RPi CS_N falls during LOC → RPI_COLLIDE one pulse, RPI_BUSY=1, downstream never shows RPi SCK; after the RPi CS_N rises and a new frame starts in IDLE, it is granted.
- TIMEOUT_CYCLES=20, LOC_REQ stuck high → LOC_GNT high 20 cycles, TIMEOUT_ERR pulse, GUARD, then re-grant to LOC.
- RST asserted mid RPi frame with CS_N still low → SPI_CS_N_OUT=1 immediately; no grant until CS_N high then low again.
